id_ex_pipe_reg: RTL and testbench

Parametrised decode→execute pipeline register with an elastic valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter. It sits between the decode stage (register-file read, immediate generation) and the ALU/execute stage. It replaces the free-running latch between those stages. Execute-side backpressure does not combinationally reach decode. Flushed or invalid slots never produce a register write.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_buf.sv | 77 +++++++
 rtl/id_ex_pipe_reg.sv | 79 +++++++
 tb/tb_id_ex_pipe_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for the decode/execute pipeline register
package pipe_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_ALUOP_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [DEF_ALUOP_W-1:0] alu_op;
    logic [DEF_RADDR_W-1:0] rd;
    logic [DEF_XLEN-1:0]    op1;
    logic [DEF_XLEN-1:0]    op2;
    logic [DEF_XLEN-1:0]    imm;
    logic                   reg_wr_en;
    logic                   flag;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic two-slot skid buffer with flush; ready/valid decoded from state only
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  pipe_state_t  state, state_nxt;
  logic [W-1:0] skid_data;
  logic         in_fire, out_fire;
  logic         load_main, load_skid, main_from_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // main only changes on a load, so it stays stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_main)           out_data <= in_data;
      else if (main_from_skid) out_data <= skid_data;
      if (load_skid)           skid_data <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode->execute pipeline register with skid buffer, flush and stall counter
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int RADDR_W     = DEF_RADDR_W,
  parameter int ALUOP_W     = DEF_ALUOP_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_W-1:0]     in_alu_op,
  input  logic [RADDR_W-1:0]     in_rd,
  input  logic [XLEN-1:0]        in_op1,
  input  logic [XLEN-1:0]        in_op2,
  input  logic [XLEN-1:0]        in_imm,
  input  logic                   in_reg_wr_en,
  input  logic                   in_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALUOP_W-1:0]     out_alu_op,
  output logic [RADDR_W-1:0]     out_rd,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_reg_wr_en,
  output logic                   out_flag,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // same layout as id_ex_payload_t, but sized by this instance's parameters
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    imm;
    logic               reg_wr_en;
    logic               flag;
  } payload_t;

  localparam int W = $bits(payload_t);

  payload_t in_pl, out_pl;

  assign in_pl = {in_alu_op, in_rd, in_op1, in_op2, in_imm, in_reg_wr_en, in_flag};

  pipe_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_alu_op    = out_pl.alu_op;
  assign out_rd        = out_pl.rd;
  assign out_op1       = out_pl.op1;
  assign out_op2       = out_pl.op2;
  assign out_imm       = out_pl.imm;
  assign out_flag      = out_pl.flag;
  assign out_reg_wr_en = out_pl.reg_wr_en & out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && stall_cnt != {STALL_CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic        wr;
    logic        flag;
  } pl_t;

  typedef struct {
    pl_t pl;
    int  due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_op = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_op1 = '0, in_op2 = '0, in_imm = '0;
  logic        in_reg_wr_en = 1'b0, in_flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic [31:0] out_op1, out_op2, out_imm;
  logic        out_reg_wr_en, out_flag;
  logic [2:0]  stall_cnt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];

  id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .ALUOP_W(4), .STALL_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_rd(in_rd), .in_op1(in_op1), .in_op2(in_op2),
    .in_imm(in_imm), .in_reg_wr_en(in_reg_wr_en), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_reg_wr_en(out_reg_wr_en), .out_flag(out_flag),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic pl_t mk(input logic [4:0] rd, input logic [31:0] op1);
    pl_t p;
    p.alu_op = rd[3:0];
    p.rd     = rd;
    p.op1    = op1;
    p.op2    = op1 ^ 32'hFFFF_0000;
    p.imm    = 32'h0000_1000 + {27'd0, rd};
    p.wr     = rd[0] | rd[1];
    p.flag   = rd[2];
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // one cycle of stimulus; push=1 records the beat as expected, timed=1 also fixes its output cycle
  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] op1,
                      input bit ordy, input bit fl, input bit push, input bit timed);
    pl_t  p;
    exp_t e;
    @(posedge clk); #1;
    p = mk(rd, op1);
    in_valid = v; out_ready = ordy; flush = fl;
    {in_alu_op, in_rd, in_op1, in_op2, in_imm, in_reg_wr_en, in_flag} = p;
    if (push) begin
      e.pl  = p;
      e.due = timed ? cyc + 1 : -1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out actual_rd=%0d required=none", out_rd);
      end else begin
        exp_t e;
        pl_t  got;
        e   = q.pop_front();
        got = {out_alu_op, out_rd, out_op1, out_op2, out_imm, out_reg_wr_en, out_flag};
        if (got !== e.pl || (e.due >= 0 && cyc != e.due)) begin
          failures++;
          $display("FAIL sb_out actual_rd=%0d op1=0x%0h cyc=%0d required_rd=%0d op1=0x%0h cyc=%0d",
                   out_rd, out_op1, cyc, e.pl.rd, e.pl.op1, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held two cycles with a valid instruction presented
    in_valid = 1'b1; out_ready = 1'b1;
    {in_alu_op, in_rd, in_op1, in_op2, in_imm, in_reg_wr_en, in_flag} = mk(5'd9, 32'h99);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_op1", out_op1, 0);
      chk("rst_wr_en", out_reg_wr_en, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // back-to-back streaming, each beat due one cycle after its accept
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 5'(i), 32'(16 * i), 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1);
    end
    idle(2, 1'b1);

    // backpressure: rd=4 goes to skid while rd=3 is held
    step(1'b1, 5'd3, 32'h30, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd4, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_rd", out_rd, 3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_hold_rd2", out_rd, 3);
    chk("bp_hold_op1", out_op1, 32'h30);
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_drain_rd4", out_rd, 4);
    chk("bp_in_ready_back", in_ready, 1);
    idle(2, 1'b1);

    // flush in BUSY together with an accepted beat
    step(1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd11, 32'hB0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_wr_en_before_flush", out_reg_wr_en, 1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_busy_out_valid", out_valid, 0);
    chk("flush_busy_in_ready", in_ready, 1);
    chk("flush_busy_wr_en", out_reg_wr_en, 0);

    // flush in FULL with decode still presenting
    step(1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd13, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd14, 32'hE0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_before_flush_in_ready", in_ready, 0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_full_out_valid", out_valid, 0);
    chk("flush_full_in_ready", in_ready, 1);
    chk("flush_full_wr_en", out_reg_wr_en, 0);
    idle(3, 1'b1);
    step(1'b1, 5'd15, 32'hF0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("sb_queue_empty", q.size(), 0);

    // stall counter saturation at 7, cleared only by rst
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    step(1'b1, 5'd5, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_start", stall_cnt, 0);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("stall_count", stall_cnt, (j > 7) ? 7 : j);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("stall_before_rst_edge", stall_cnt, 7);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("stall_after_rst", stall_cnt, 0);
    chk("out_valid_after_rst", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
